sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Two-port arbiter sharing the single SDRAM controller native port between the CPU bus bridge (port 0) and a DMA/video requester (port 1).
- Round-robin grant, one outstanding transaction at a time, single-beat reads and writes.
- Read-timeout watchdog so a lost read response cannot hang the 65C02 (RDY held low forever).
- Sits between the requesters and the SDRAM controller in the i_sysclk domain.

Parameters:
- ADDR_WIDTH, 24, word address width presented to the SDRAM controller.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, i_sysclk cycles to wait for read data after command acceptance before aborting; must be at least 1.

Ports:
- i_sysclk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_req0_valid, i_req1_valid  in  1 each  request pending; held with all fields stable until the matching ready.
- i_req0_we, i_req1_we  in  1 each  1 = write, 0 = read.
- i_req0_addr, i_req1_addr  in  ADDR_WIDTH each  word address.
- i_req0_wdata, i_req1_wdata  in  DATA_WIDTH each  write data.
- i_req0_be, i_req1_be  in  DATA_WIDTH/8 each  byte enables (writes only).
- o_req0_ready, o_req1_ready  out  1 each  one-cycle completion pulse.
- o_req0_rdata, o_req1_rdata  out  DATA_WIDTH each  read data, valid with ready.
- o_mem_req  out  1  command valid to the controller.
- o_mem_we  out  1  command type.
- o_mem_addr  out  ADDR_WIDTH  command address.
- o_mem_wdata  out  DATA_WIDTH  command write data.
- o_mem_be  out  DATA_WIDTH/8  command byte enables.
- i_mem_ack  in  1  controller accepted the command this cycle.
- i_mem_rvalid  in  1  read data valid.
- i_mem_rdata  in  DATA_WIDTH  read data.
- o_busy  out  1  state is not IDLE.
- o_timeout  out  1  sticky: a read timed out since reset.

Behaviour:
- Clock and reset: one clock, i_sysclk. i_rst is synchronous and active-high. All outputs are registered.
- Reset values: all outputs 0. State is IDLE, the priority pointer favours port 0, the timeout counter is 0 and o_timeout is cleared.
- Reset mid-operation: the block returns to IDLE next cycle and o_mem_req drops. A late i_mem_rvalid from the aborted read is ignored; the requester sees no ready.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If exactly one valid, grant that port.
  - If both are valid, grant the port the pointer favours.
  - On grant: latch we/addr/wdata/be and the port index into command registers, point the pointer at the other port, go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - o_mem_req=1 with the latched fields, held stable until i_mem_ack.
  - On ack with write: pulse the granted port's ready, go to IDLE.
  - On ack with read: clear the timeout counter, go to WAIT_RD.
  - Ack and rvalid in the same cycle for a read: capture the data, pulse ready, go directly to IDLE.
  - o_mem_req deasserts the cycle after ack.
- WAIT_RD:
  - On i_mem_rvalid: register i_mem_rdata onto the granted port's rdata, pulse its ready, go to IDLE.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES-1 without rvalid: pulse ready with rdata = all ones, set o_timeout, go to IDLE.
  - If rvalid and timeout fall in the same cycle, rvalid wins and o_timeout is not set.
- Unexpected rvalid: i_mem_rvalid outside WAIT_RD (or outside the ISSUE same-cycle case) is ignored.
- rdata hold: rdata of the non-granted port holds its last value. Only the granted port's ready can pulse.
- Latency:
  - Write: valid in IDLE → o_mem_req next cycle. With immediate ack, ready comes 2 cycles after the grant cycle.
  - Read: ready comes 1 cycle after rvalid.
  - There is a mandatory IDLE cycle between transactions, so the same port cannot be regranted while its ready is pulsing. The requester drops valid or presents the next request after ready.
- Fairness: the pointer only moves on a grant. A lone requester can take every slot, and under constant contention the ports strictly alternate.

Decomposition:
- Shared package sdram_arb_pkg: state enum (IDLE, ISSUE, WAIT_RD), port index constants (PORT_CPU=0, PORT_DMA=1), and a command struct (we, addr, wdata, be) parameterised by the package localparams that match the SDRAM controller widths.
- Single module. No sub-module is needed; the timeout counter is inline.

Test Plan:
- Single write, port 0: addr 0x000123, wdata 0xDEADBEEF, be 0xF, ack 1 cycle after req → o_mem_req for 2 cycles with those fields; o_req0_ready pulses once; port 1 is never ready.
- Read, port 1: addr 0x00ABCD; controller acks, then rvalid 6 cycles later with 0x12345678 → o_req1_rdata=0x12345678 with a one-cycle ready; o_timeout stays 0.
- Both valid continuously, 4 writes each → grant order 0,1,0,1,0,1,0,1 after reset; each request's fields appear unaltered on o_mem_*.
- Read with no rvalid, TIMEOUT_CYCLES=8 → ready pulses with rdata=0xFFFFFFFF; o_timeout=1 and stays set until i_rst.
- Same-cycle ack+rvalid on a read → ready the next cycle, no WAIT_RD visit. Separately, rvalid arriving while in IDLE → no ready and no state change.
- i_rst asserted in WAIT_RD, then rvalid 2 cycles later → all outputs 0, no ready. A port 0 request presented after reset is granted first.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
// Widths track the SDRAM controller native port.
package sdram_arb_pkg;

  localparam int unsigned SDRAM_ADDR_WIDTH = 24;
  localparam int unsigned SDRAM_DATA_WIDTH = 32;
  localparam int unsigned SDRAM_BE_WIDTH   = SDRAM_DATA_WIDTH / 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRd
  } arb_state_e;

  typedef struct packed {
    logic                        we;
    logic [SDRAM_ADDR_WIDTH-1:0] addr;
    logic [SDRAM_DATA_WIDTH-1:0] wdata;
    logic [SDRAM_BE_WIDTH-1:0]   be;
  } mem_cmd_t;

endpackage

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller port between CPU (port 0) and DMA (port 1),
// one single-beat transaction at a time, with a read-response watchdog.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  // Widths must match the package command struct.
  parameter int unsigned ADDR_WIDTH     = SDRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = SDRAM_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    i_sysclk,
  input  logic                    i_rst,
  input  logic                    i_req0_valid,
  input  logic                    i_req0_we,
  input  logic [ADDR_WIDTH-1:0]   i_req0_addr,
  input  logic [DATA_WIDTH-1:0]   i_req0_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_req0_be,
  output logic                    o_req0_ready,
  output logic [DATA_WIDTH-1:0]   o_req0_rdata,
  input  logic                    i_req1_valid,
  input  logic                    i_req1_we,
  input  logic [ADDR_WIDTH-1:0]   i_req1_addr,
  input  logic [DATA_WIDTH-1:0]   i_req1_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_req1_be,
  output logic                    o_req1_ready,
  output logic [DATA_WIDTH-1:0]   o_req1_rdata,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  input  logic                    i_mem_ack,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_busy,
  output logic                    o_timeout
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  arb_state_e            state_q, state_d;
  mem_cmd_t              cmd_q, cmd_d;
  logic                  port_q, port_d;
  logic                  ptr_q, ptr_d;
  logic                  mem_req_q, mem_req_d;
  logic [1:0]            ready_q, ready_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  busy_q, busy_d;

  logic [1:0]            elig;
  logic                  gnt;
  logic                  done;
  logic                  rd_done;
  logic [DATA_WIDTH-1:0] rd_val;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    port_d    = port_q;
    ptr_d     = ptr_q;
    mem_req_d = mem_req_q;
    ready_d   = 2'b00;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    gnt       = 1'b0;
    done      = 1'b0;
    rd_done   = 1'b0;
    rd_val    = '1;
    // A port whose ready is pulsing is still holding its old request; skip it this cycle.
    elig      = {i_req1_valid & ~ready_q[1], i_req0_valid & ~ready_q[0]};

    unique case (state_q)
      StIdle: begin
        if (elig != 2'b00) begin
          gnt       = (elig == 2'b11) ? ptr_q : elig[1];
          port_d    = gnt;
          ptr_d     = ~gnt;
          cmd_d     = (gnt == PORT_DMA) ?
                      '{we: i_req1_we, addr: i_req1_addr, wdata: i_req1_wdata, be: i_req1_be} :
                      '{we: i_req0_we, addr: i_req0_addr, wdata: i_req0_wdata, be: i_req0_be};
          mem_req_d = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (i_mem_ack) begin
          mem_req_d = 1'b0;
          if (cmd_q.we) begin
            done    = 1'b1;
            state_d = StIdle;
          end else if (i_mem_rvalid) begin
            done    = 1'b1;
            rd_done = 1'b1;
            rd_val  = i_mem_rdata;
            state_d = StIdle;
          end else begin
            cnt_d   = '0;
            state_d = StWaitRd;
          end
        end
      end
      StWaitRd: begin
        if (i_mem_rvalid) begin
          done    = 1'b1;
          rd_done = 1'b1;
          rd_val  = i_mem_rdata;
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          done      = 1'b1;
          rd_done   = 1'b1;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (done) begin
      ready_d[port_q] = 1'b1;
    end
    if (rd_done) begin
      if (port_q == PORT_DMA) rdata1_d = rd_val;
      else                    rdata0_d = rd_val;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      port_q    <= PORT_CPU;
      ptr_q     <= PORT_CPU;
      mem_req_q <= 1'b0;
      ready_q   <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      port_q    <= port_d;
      ptr_q     <= ptr_d;
      mem_req_q <= mem_req_d;
      ready_q   <= ready_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign o_mem_req    = mem_req_q;
  assign o_mem_we     = cmd_q.we;
  assign o_mem_addr   = cmd_q.addr;
  assign o_mem_wdata  = cmd_q.wdata;
  assign o_mem_be     = cmd_q.be;
  assign o_req0_ready = ready_q[0];
  assign o_req1_ready = ready_q[1];
  assign o_req0_rdata = rdata0_q;
  assign o_req1_rdata = rdata1_q;
  assign o_busy       = busy_q;
  assign o_timeout    = timeout_q;

endmodule
